// File: rtl/lag_line.sv
// -----------------------------------------------------------------------------
// lag_line -- programmable sample delay line.
//
// Each enable strobe writes one DATA_W-bit sample into a DEPTH-entry circular
// buffer. One cycle later the block presents the sample that arrived lag_sel
// strobes earlier, together with a one-cycle valid pulse.
//
// lag_sel = 0 returns the sample written by that same strobe. This path uses a
// bypass register, because the buffer read of mem[wp] would return the stale
// entry that is being overwritten.
//
// When the requested lag reaches back beyond the samples seen since reset,
// signal_lag is forced to zero and primed stays low. The buffer itself is never
// cleared; the fill count masks stale entries instead.
//
// Optional feature: define LAG_DUAL_TAP_EN to add a second read tap. The tap
// adds the input lag_sel_b and the outputs signal_lag_b and primed_b. It reads
// the same buffer under the same rules and shares valid with the first tap.
//
// DEPTH must be a power of two (minimum 2) and LAG_W must equal log2(DEPTH).
// The write pointer wraps by plain LAG_W-bit overflow.
// -----------------------------------------------------------------------------
module lag_line #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int LAG_W  = 4
) (
    input  logic              clk_operation,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] signal,
    input  logic [LAG_W-1:0]  lag_sel,
`ifdef LAG_DUAL_TAP_EN
    input  logic [LAG_W-1:0]  lag_sel_b,
    output logic [DATA_W-1:0] signal_lag_b,
    output logic              primed_b,
`endif
    output logic [DATA_W-1:0] signal_lag,
    output logic              valid,
    output logic              primed
);

`ifdef LAG_DUAL_TAP_EN
    localparam int NUM_TAPS = 2;
`else
    localparam int NUM_TAPS = 1;
`endif

    // The fill count needs one extra bit so that it can hold DEPTH itself.
    localparam int CNT_W = LAG_W + 1;

    // -------------------------------------------------------------------------
    // Storage and shared write-side state
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    logic [LAG_W-1:0]  wp_reg;
    logic [LAG_W-1:0]  wp_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              valid_reg;
    logic [DATA_W-1:0] bypass_data_reg;

    // Per-tap lag requests and results, gathered into arrays so that both taps
    // can be built by the same generate loop.
    logic [LAG_W-1:0]  tap_lag    [NUM_TAPS];
    logic [DATA_W-1:0] tap_data   [NUM_TAPS];
    logic              tap_primed [NUM_TAPS];

    assign tap_lag[0] = lag_sel;
`ifdef LAG_DUAL_TAP_EN
    assign tap_lag[1] = lag_sel_b;
`endif

    // Next write pointer wraps naturally; the fill count saturates at DEPTH.
    always_comb begin
        wp_next  = wp_reg + LAG_W'(1);
        cnt_next = cnt_reg;
        if (cnt_reg != CNT_W'(DEPTH)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Write pointer, fill count and valid pulse. Reset wins over enable.
    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            wp_reg    <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= enable;
            if (enable) begin
                wp_reg  <= wp_next;
                cnt_reg <= cnt_next;
            end
        end
    end

    // Buffer write. This port has no reset, so the array can map onto block RAM.
    always_ff @(posedge clk_operation) begin
        if (rst && enable) begin
            mem[wp_reg] <= signal;
        end
    end

    // Capture the incoming sample for the lag-0 pass-through. This register is
    // shared by all taps and is masked by each tap's primed flag after reset.
    always_ff @(posedge clk_operation) begin
        if (enable) begin
            bypass_data_reg <= signal;
        end
    end

    // -------------------------------------------------------------------------
    // Read taps
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            logic [LAG_W-1:0]  rd_addr;
            logic              has_history;
            logic              is_lag0;
            logic [DATA_W-1:0] rd_data_reg;
            logic              primed_reg;
            logic              bypass_sel_reg;

            // The sample lag strobes back sits lag slots behind the current
            // write slot. The fill count is compared after this strobe's
            // increment, so that lag 0 counts as available on the first strobe.
            assign rd_addr     = wp_reg - tap_lag[gi];
            assign has_history = {1'b0, tap_lag[gi]} < cnt_next;
            assign is_lag0     = (tap_lag[gi] == '0);

            // Registered buffer read, taken only on strobes so the value holds
            // between strobes.
            always_ff @(posedge clk_operation) begin
                if (enable) begin
                    rd_data_reg <= mem[rd_addr];
                end
            end

            // Per-tap qualifiers: history available and lag-0 bypass selected.
            always_ff @(posedge clk_operation) begin
                if (!rst) begin
                    primed_reg     <= 1'b0;
                    bypass_sel_reg <= 1'b0;
                end else if (enable) begin
                    primed_reg     <= has_history;
                    bypass_sel_reg <= is_lag0;
                end
            end

            // Insufficient history yields zero. Otherwise pick the bypass or
            // the buffer read.
            assign tap_data[gi]   = primed_reg
                                  ? (bypass_sel_reg ? bypass_data_reg : rd_data_reg)
                                  : '0;
            assign tap_primed[gi] = primed_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign signal_lag = tap_data[0];
    assign primed     = tap_primed[0];
    assign valid      = valid_reg;

`ifdef LAG_DUAL_TAP_EN
    assign signal_lag_b = tap_data[1];
    assign primed_b     = tap_primed[1];
`endif

endmodule

// File: doc/lag_line.md
LAG_LINE -- requirements
Module: lag_line

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the sample width in bits (IEEE-754 double from the sig16b_to_double stage).
REQ-002 SHALL have parameter DEPTH, default 16, the history length in samples; a power of two, minimum 2.
REQ-003 SHALL have parameter LAG_W, default 4, the lag-select width, equal to log2(DEPTH).
REQ-004 SHALL have port clk_operation, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: sample strobe; each high cycle accepts one sample.
REQ-007 SHALL have port signal, input, DATA_W bits: the incoming sample, captured when enable=1.
REQ-008 SHALL have port lag_sel, input, LAG_W bits: requested lag in samples, 0..DEPTH-1.
REQ-009 SHALL have port signal_lag, output, DATA_W bits: the lagged sample, registered.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse marking a new signal_lag.
REQ-011 SHALL have port primed, output, 1 bit: high when the last signal_lag came from real history.

Function
REQ-012 SHALL store samples in a circular buffer of DEPTH entries, with write pointer wp (LAG_W bits) and fill count cnt (0..DEPTH, saturating).
REQ-013 SHALL, on a cycle with enable=1, write signal to mem[wp], advance wp by 1 modulo DEPTH (DEPTH-1 wraps to 0), and increment cnt saturating at DEPTH.
REQ-014 SHALL sample lag_sel only in enable cycles; a lag_sel change between strobes takes effect at the next strobe.
REQ-015 SHALL, in the cycle after an enable, drive valid=1 for exactly one cycle and present the sample accepted lag_sel strobes earlier (latency 1 cycle).
REQ-016 SHALL make lag_sel=0 return the sample accepted in that same strobe, i.e. a one-cycle registered pass-through.
REQ-017 SHALL, when lag_sel >= cnt after the increment (insufficient history), output signal_lag=0 and primed=0 with valid=1; otherwise it outputs the stored sample with primed=1.
REQ-018 SHALL hold signal_lag and primed unchanged when enable=0; valid=0 in that case.
REQ-019 SHALL accept enable held high continuously as one sample per cycle; valid is then continuously high and each cycle's output follows REQ-015.
REQ-020 SHALL resolve the write and lagged read of the same strobe so that lag_sel=0 returns the new sample, never the stale contents of mem[wp].
REQ-021 SHALL pass DATA_W bits unmodified; no arithmetic is performed on sample data.

Reset
REQ-022 SHALL, with rst=0 at a rising edge, set wp=0, cnt=0, signal_lag=0, valid=0 and primed=0, overriding enable in that cycle.
REQ-023 SHALL NOT clear buffer memory on reset; stale entries are masked by cnt=0 per REQ-017.
REQ-024 SHALL, after a mid-stream reset, behave exactly as from power-up; no pre-reset sample may appear at signal_lag.

Configuration
REQ-025 SHALL, with macro LAG_DUAL_TAP_EN defined, add the following second tap:
- input lag_sel_b (LAG_W bits) and outputs signal_lag_b (DATA_W bits) and primed_b (1 bit);
- read from the same buffer with identical rules (REQ-014..REQ-020), sharing valid.
REQ-026 SHALL, without LAG_DUAL_TAP_EN, omit these ports and the second read path entirely.

Verification
REQ-027 SHALL cover: reset, then strobes with signal=1,2,3,4 and lag_sel=2 -> outputs 0(p=0), 0(p=0), 1(p=1), 2(p=1).
REQ-028 SHALL cover: lag_sel=0 with signal=0x3FF0000000000000 strobed -> next cycle signal_lag=0x3FF0000000000000, valid=1, primed=1.
REQ-029 SHALL cover: 20 continuous strobes, values 1..20, lag_sel=15 -> strobe 20 outputs 5 with primed=1, proving wp wrap and cnt saturation at 16.
REQ-030 SHALL cover: 5 strobes (values 1..5), then rst=0 for one cycle, then strobe value 9 with lag_sel=3 -> signal_lag=0, primed=0.
REQ-031 SHALL cover: lag_sel changed 1->3 while enable=0 -> outputs hold; next strobe uses lag 3.
REQ-032 SHALL cover: with LAG_DUAL_TAP_EN, lag_sel=1 and lag_sel_b=4 over values 1..6 -> final strobe gives signal_lag=5 and signal_lag_b=2.
